stream_demux: RTL and testbench

// - 1-to-2 demultiplexer for a 32-bit valid/ready stream; the inverse of the 2:1 word mux (input1/input2/selector -> out).
// - Routes each input word to output 0 or output 1.
// - Packet-aware: the route is sampled on the first beat of a packet and locked until the beat with in_last=1.
// - Each output has a one-entry registered stage; per-output beat counters for the lab's debug/stat taps.

---
 rtl/stream_demux_if.sv | 32 +++
 rtl/stream_demux.sv | 123 ++++++++++++
 tb/tb_stream_demux.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - handshake bundle for the 1:2 stream demultiplexer
interface stream_demux_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;

  // Producer of input words and consumer of both outputs
  modport master (
    output in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last,
    input  out1_valid, out1_data, out1_last
  );

  // The demux itself
  modport slave (
    input  in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last,
    output out1_valid, out1_data, out1_last
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-aware 1:2 stream demultiplexer with beat counters
module stream_demux #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    s,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             tgt;
  logic             slot0_free;
  logic             slot1_free;
  logic             accept;
  logic             load0;
  logic             load1;
  logic             out0_valid_q;
  logic             out1_valid_q;
  logic [WIDTH-1:0] out0_data_q;
  logic [WIDTH-1:0] out1_data_q;
  logic             out0_last_q;
  logic             out1_last_q;

  // A slot may drain and refill in the same cycle, so a held word whose
  // consumer is ready counts as free.
  assign slot0_free = !out0_valid_q || s.out0_ready;
  assign slot1_free = !out1_valid_q || s.out1_ready;

  // Route selection and input handshake; in_sel only matters between packets
  always_comb begin
    tgt       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    tgt = s.in_sel;
      LOCK0:   tgt = 1'b0;
      LOCK1:   tgt = 1'b1;
      default: tgt = 1'b0;
    endcase
    s.in_ready = tgt ? slot1_free : slot0_free;
    accept     = s.in_valid && s.in_ready;
    load0      = accept && !tgt;
    load1      = accept && tgt;
    if (accept) begin
      if (s.in_last) begin
        state_nxt = IDLE;
      end else if (state == IDLE) begin
        state_nxt = s.in_sel ? LOCK1 : LOCK0;
      end
    end
  end

  // Packet lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output 0 stage: load on accept, clear valid on handshake, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out0_last_q  <= 1'b0;
    end else if (load0) begin
      out0_valid_q <= 1'b1;
      out0_data_q  <= s.in_data;
      out0_last_q  <= s.in_last;
    end else if (s.out0_ready) begin
      out0_valid_q <= 1'b0;
    end
  end

  // Output 1 stage: load on accept, clear valid on handshake, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid_q <= 1'b0;
      out1_data_q  <= '0;
      out1_last_q  <= 1'b0;
    end else if (load1) begin
      out1_valid_q <= 1'b1;
      out1_data_q  <= s.in_data;
      out1_last_q  <= s.in_last;
    end else if (s.out1_ready) begin
      out1_valid_q <= 1'b0;
    end
  end

  // Delivered-beat counters; natural wrap at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid_q && s.out0_ready) cnt0 <= cnt0 + CNT_ONE;
      if (out1_valid_q && s.out1_ready) cnt1 <= cnt1 + CNT_ONE;
    end
  end

  assign s.out0_valid = out0_valid_q;
  assign s.out0_data  = out0_data_q;
  assign s.out0_last  = out0_last_q;
  assign s.out1_valid = out1_valid_q;
  assign s.out1_data  = out1_data_q;
  assign s.out1_last  = out1_last_q;
  assign busy         = (state != IDLE) || out0_valid_q || out1_valid_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed self-checking bench for stream_demux
module tb_stream_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_cnt0, a_cnt1;
  logic        a_busy;
  logic [3:0]  b_cnt0, b_cnt1;
  logic        b_busy;
  int          errors = 0;
  int          checks = 0;

  stream_demux_if #(.WIDTH(32)) a ();
  stream_demux_if #(.WIDTH(32)) b ();

  stream_demux #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s(a), .cnt0(a_cnt0), .cnt1(a_cnt1), .busy(a_busy)
  );

  stream_demux #(.WIDTH(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .s(b), .cnt0(b_cnt0), .cnt1(b_cnt1), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic sel, input logic [31:0] d, input logic l);
    a.in_valid = v;
    a.in_sel   = sel;
    a.in_data  = d;
    a.in_last  = l;
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    a.out0_ready = 1'b1;
    a.out1_ready = 1'b1;
    b.in_valid = 1'b0; b.in_sel = 1'b0; b.in_data = '0; b.in_last = 1'b0;
    b.out0_ready = 1'b1;
    b.out1_ready = 1'b1;

    tick(); tick();
    check("rst_out0_valid", {31'b0, a.out0_valid}, 32'h0);
    check("rst_out1_valid", {31'b0, a.out1_valid}, 32'h0);
    check("rst_out0_data", a.out0_data, 32'h0);
    check("rst_cnt0", {16'b0, a_cnt0}, 32'h0);
    check("rst_busy", {31'b0, a_busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single-beat packets to out0 then out1
    drive_a(1'b1, 1'b0, 32'h1, 1'b1);
    #1 check("sb_in_ready", {31'b0, a.in_ready}, 32'h1);
    tick();
    drive_a(1'b1, 1'b1, 32'h2, 1'b1);
    check("sb_out0_valid", {31'b0, a.out0_valid}, 32'h1);
    check("sb_out0_data", a.out0_data, 32'h1);
    check("sb_out0_last", {31'b0, a.out0_last}, 32'h1);
    check("sb_out1_idle", {31'b0, a.out1_valid}, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    check("sb_out1_data", a.out1_data, 32'h2);
    check("sb_out1_valid", {31'b0, a.out1_valid}, 32'h1);
    check("sb_out0_drained", {31'b0, a.out0_valid}, 32'h0);
    tick();
    check("sb_cnt0", {16'b0, a_cnt0}, 32'h1);
    check("sb_cnt1", {16'b0, a_cnt1}, 32'h1);
    check("sb_busy", {31'b0, a_busy}, 32'h0);

    // Packet lock: sel toggles after the first beat but route stays on out1
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, (i % 2 == 0), 32'hA0 + i, (i == 3));
      tick();
      check("lock_out1_data", a.out1_data, 32'hA0 + i);
      check("lock_out1_last", {31'b0, a.out1_last}, (i == 3) ? 32'h1 : 32'h0);
      check("lock_out0_idle", {31'b0, a.out0_valid}, 32'h0);
    end
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("lock_cnt1", {16'b0, a_cnt1}, 32'h5);
    check("lock_cnt0", {16'b0, a_cnt0}, 32'h1);
    check("lock_busy", {31'b0, a_busy}, 32'h0);

    // Backpressure on out0 during a 3-beat packet
    a.out0_ready = 1'b0;
    drive_a(1'b1, 1'b0, 32'hB0, 1'b0);
    #1 check("bp_first_ready", {31'b0, a.in_ready}, 32'h1);
    tick();
    drive_a(1'b1, 1'b1, 32'hB1, 1'b0);
    #1 check("bp_blocked", {31'b0, a.in_ready}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", a.out0_data, 32'hB0);
      check("bp_hold_ready", {31'b0, a.in_ready}, 32'h0);
      check("bp_out1_idle", {31'b0, a.out1_valid}, 32'h0);
    end
    a.out0_ready = 1'b1;
    #1 check("bp_release_ready", {31'b0, a.in_ready}, 32'h1);
    tick();
    check("bp_b1", a.out0_data, 32'hB1);
    check("bp_cnt0_a", {16'b0, a_cnt0}, 32'h2);
    drive_a(1'b1, 1'b1, 32'hB2, 1'b1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    check("bp_b2", a.out0_data, 32'hB2);
    check("bp_b2_last", {31'b0, a.out0_last}, 32'h1);
    tick();
    check("bp_cnt0_b", {16'b0, a_cnt0}, 32'h4);
    check("bp_drained", {31'b0, a.out0_valid}, 32'h0);
    check("bp_cnt1", {16'b0, a_cnt1}, 32'h5);

    // Cross-output stall: out1 holds 0x55 while out0 keeps flowing
    a.out1_ready = 1'b0;
    drive_a(1'b1, 1'b1, 32'h55, 1'b1);
    tick();
    drive_a(1'b1, 1'b0, 32'h66, 1'b1);
    #1 check("x_in_ready_sel0", {31'b0, a.in_ready}, 32'h1);
    tick();
    check("x_out0_data", a.out0_data, 32'h66);
    check("x_out0_valid", {31'b0, a.out0_valid}, 32'h1);
    check("x_out1_held", a.out1_data, 32'h55);
    drive_a(1'b0, 1'b1, 32'h0, 1'b0);
    #1 check("x_in_ready_sel1", {31'b0, a.in_ready}, 32'h0);
    a.out1_ready = 1'b1;
    tick();
    check("x_cnt0", {16'b0, a_cnt0}, 32'h5);
    check("x_cnt1", {16'b0, a_cnt1}, 32'h6);

    // Reset mid-packet with out1 holding a word
    a.out1_ready = 1'b0;
    drive_a(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    check("r_held", a.out1_data, 32'hDEADBEEF);
    check("r_busy_pre", {31'b0, a_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("r_out1_valid", {31'b0, a.out1_valid}, 32'h0);
    check("r_cnt1", {16'b0, a_cnt1}, 32'h0);
    check("r_busy", {31'b0, a_busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    a.out1_ready = 1'b1;
    drive_a(1'b1, 1'b0, 32'h7, 1'b1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    check("r_idle_route", a.out0_data, 32'h7);
    check("r_no_partial", {31'b0, a.out1_valid}, 32'h0);

    // Counter wrap on the narrow-counter instance
    b.in_valid = 1'b1; b.in_sel = 1'b0; b.in_last = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b.in_data = 32'h100 + i;
      tick();
    end
    b.in_valid = 1'b0;
    tick();
    check("w_cnt0", {28'b0, b_cnt0}, 32'h1);
    check("w_cnt1", {28'b0, b_cnt1}, 32'h0);
    b.out0_ready = 1'b0;
    b.out1_ready = 1'b0;
    b.in_valid = 1'b1; b.in_sel = 1'b0; b.in_data = 32'hC0;
    tick();
    b.in_sel = 1'b1; b.in_data = 32'hC1;
    tick();
    b.in_valid = 1'b0;
    check("w_both_held", {30'b0, b.out1_valid, b.out0_valid}, 32'h3);
    b.out0_ready = 1'b1;
    b.out1_ready = 1'b1;
    tick();
    check("w_sim_cnt0", {28'b0, b_cnt0}, 32'h2);
    check("w_sim_cnt1", {28'b0, b_cnt1}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
